// File: rtl/ram_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: RAM address/word types, owner enum,
// and the request bundle used by both requester ports and the RAM mux.
// No ports; imported by ram_arbiter and arb_sat_counter users.
package ram_arbiter_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int WORD_W     = 32;

  typedef logic [RAM_ADDR_W-1:0] RamAddress;
  typedef logic [WORD_W-1:0]     Word;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_X = 1'b1
  } ArbOwner;

  typedef struct packed {
    logic      write;
    RamAddress address;
    Word       write_data;
  } RamRequest;

endpackage

// File: rtl/ram_arbiter_sat.sv
// arb_sat_counter: W-bit up-counter that sticks at all-ones, with clear.
// Ports: clk, reset (async active-high), inc, clr (wins over inc), cnt.
// Used for the starvation/lock counters and the optional perf counters.
module arb_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the CPU (port C, default
// owner) and an external master (port X). Ports: clk/reset, C request + ack/stall,
// X request (+lock) + ack, broadcast rd_data, sticky lock_error, RAM side.
// Optional macro RAM_ARB_PERF_EN adds c_stall_cycles / x_grant_cycles counters.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_LIMIT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_write,
  input  logic [RAM_ADDR_W-1:0] c_address,
  input  logic [WORD_W-1:0]     c_write_data,
  output logic                  c_ack,
  output logic                  c_stall,
  input  logic                  x_req,
  input  logic                  x_write,
  input  logic                  x_lock,
  input  logic [RAM_ADDR_W-1:0] x_address,
  input  logic [WORD_W-1:0]     x_write_data,
  output logic                  x_ack,
  output logic [WORD_W-1:0]     rd_data,
  output logic                  lock_error,
`ifdef RAM_ARB_PERF_EN
  output logic [31:0]           c_stall_cycles,
  output logic [31:0]           x_grant_cycles,
`endif
  output logic [RAM_ADDR_W-1:0] ram_address,
  output logic                  ram_write_enable,
  output logic [WORD_W-1:0]     ram_write_data,
  input  logic [WORD_W-1:0]     ram_data
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int LOCK_W   = $clog2(LOCK_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_LIMIT - 1);

  ArbOwner state_q, state_d;
  logic    lock_error_q, lock_error_d;

  logic [STARVE_W-1:0] starve_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic starve_inc, starve_clr;
  logic lock_inc, lock_clr;

  RamRequest c_r, x_r, own_r;

  // Acks are combinational and suppressed for the whole reset assertion,
  // so a reset landing mid-access can never produce a RAM write.
  assign c_ack   = c_req && (state_q == OWN_C) && !reset;
  assign x_ack   = x_req && (state_q == OWN_X) && !reset;
  assign c_stall = c_req && !c_ack;

  assign c_r   = '{write: c_write, address: c_address, write_data: c_write_data};
  assign x_r   = '{write: x_write, address: x_address, write_data: x_write_data};
  assign own_r = (state_q == OWN_X) ? x_r : c_r;

  assign ram_address      = own_r.address;
  assign ram_write_data   = own_r.write_data;
  assign ram_write_enable = own_r.write && (c_ack || x_ack);
  assign rd_data          = ram_data;
  assign lock_error       = lock_error_q;

  always_comb begin
    state_d      = state_q;
    lock_error_d = lock_error_q;
    starve_inc   = 1'b0;
    starve_clr   = 1'b0;
    lock_inc     = 1'b0;
    lock_clr     = 1'b0;
    case (state_q)
      OWN_C: begin
        lock_clr = 1'b1;
        // X takes over when the CPU is idle, or once the CPU has had its
        // STARVE_LIMIT serviced cycles while X was waiting.
        if (x_req && (!c_req || (starve_cnt == STARVE_LAST))) begin
          state_d    = OWN_X;
          starve_clr = 1'b1;
        end else if (!x_req) begin
          starve_clr = 1'b1;
        end else if (c_ack) begin
          starve_inc = 1'b1;
        end
      end
      OWN_X: begin
        starve_clr = 1'b1;
        if (x_req && x_lock) begin
          if (lock_cnt == LOCK_LAST) begin
            // Lock held too long: forced release back to the CPU.
            state_d      = OWN_C;
            lock_clr     = 1'b1;
            lock_error_d = 1'b1;
          end else begin
            lock_inc = 1'b1;
          end
        end else if (x_req && !c_req) begin
          lock_clr = 1'b1;
        end else begin
          state_d  = OWN_C;
          lock_clr = 1'b1;
        end
      end
      default: begin
        state_d = OWN_C;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= OWN_C;
      lock_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_error_q <= lock_error_d;
    end
  end

  arb_sat_counter #(.W(STARVE_W)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .cnt   (starve_cnt)
  );

  arb_sat_counter #(.W(LOCK_W)) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lock_inc),
    .clr   (lock_clr),
    .cnt   (lock_cnt)
  );

`ifdef RAM_ARB_PERF_EN
  arb_sat_counter #(.W(32)) u_c_stall_cycles (
    .clk   (clk),
    .reset (reset),
    .inc   (c_stall),
    .clr   (1'b0),
    .cnt   (c_stall_cycles)
  );

  arb_sat_counter #(.W(32)) u_x_grant_cycles (
    .clk   (clk),
    .reset (reset),
    .inc   (x_ack),
    .clr   (1'b0),
    .cnt   (x_grant_cycles)
  );
`endif

endmodule
